// File: rtl/csr_timer_ctrl_pkg.sv
// rtl/csr_timer_ctrl_pkg.sv - shared constants, register map and compare-FSM states for the machine timer
package csr_timer_ctrl_pkg;

    localparam int              TIMER_XLEN   = 64;
    localparam int              TIMER_PRESCW = 8;
    localparam logic [63:0]     TIMER_CMP_RST = '1;

    localparam logic [2:0] TIMER_MTIME_LO    = 3'd0;
    localparam logic [2:0] TIMER_MTIME_HI    = 3'd1;
    localparam logic [2:0] TIMER_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TIMER_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TIMER_CTRL        = 3'd4;
    localparam logic [2:0] TIMER_STATUS      = 3'd5;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IE_BIT       = 1;
    localparam int CTRL_PRESC_LSB    = 8;
    localparam int STATUS_MTIP_BIT   = 0;
    localparam int STATUS_LOCKED_BIT = 1;

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } cmp_state_e;

    // Addresses past STATUS do not exist; STATUS itself is read-only.
    function automatic logic access_err(input logic we, input logic [2:0] addr);
        return (addr > TIMER_STATUS) || (we && (addr == TIMER_STATUS));
    endfunction

endpackage

// File: rtl/csr_timer_ctrl_if.sv
// rtl/csr_timer_ctrl_if.sv - single-cycle request/ack register port between CSR unit and timer
interface csr_timer_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, err, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/csr_timer_ctrl_timer_counter.sv
// rtl/csr_timer_ctrl_timer_counter.sv - 64-bit mtime counter with per-half loads that win over increment
module csr_timer_ctrl_timer_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         load_lo_i,
    input  logic         load_hi_i,
    input  logic [31:0]  wdata_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_lo_i || load_hi_i) begin
            if (load_lo_i) cnt_d[31:0]  = wdata_i;
            if (load_hi_i) cnt_d[W-1:32] = wdata_i[W-33:0];
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_timer_ctrl.sv
// rtl/csr_timer_ctrl.sv - machine timer: prescaled mtime, tear-free compare update and MTIP generation
module csr_timer_ctrl
    import csr_timer_ctrl_pkg::*;
#(
    parameter int                  CSR_XLEN  = TIMER_XLEN,
    parameter int                  PRESC_W   = TIMER_PRESCW,
    parameter logic [CSR_XLEN-1:0] CMP_RESET = TIMER_CMP_RST
) (
    input  logic                clk,
    input  logic                rst_n,
    csr_timer_ctrl_if.slave     bus,
    output logic [CSR_XLEN-1:0] mtime_o,
    output logic                irq_o
);

    logic                 en_q, en_d, ie_q, ie_d;
    logic [PRESC_W-1:0]   presc_q, presc_d, pcnt_q, pcnt_d;
    logic [CSR_XLEN-33:0] snap_q, snap_d;
    logic [CSR_XLEN-1:0]  cmp_q, cmp_d, mtime;
    cmp_state_e           state_q, state_d;
    logic                 mtip_q, mtip_d, irq_q, irq_d;
    logic                 ack_q, err_q;
    logic [31:0]          rdata_q, rdata_d;

    logic acc_err, wr_ok, rd_ok, tick;
    logic wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;

    assign acc_err   = access_err(bus.we, bus.addr);
    assign wr_ok     = bus.req &  bus.we & ~acc_err;
    assign rd_ok     = bus.req & ~bus.we & ~acc_err;
    assign wr_mt_lo  = wr_ok && (bus.addr == TIMER_MTIME_LO);
    assign wr_mt_hi  = wr_ok && (bus.addr == TIMER_MTIME_HI);
    assign wr_cmp_lo = wr_ok && (bus.addr == TIMER_MTIMECMP_LO);
    assign wr_cmp_hi = wr_ok && (bus.addr == TIMER_MTIMECMP_HI);
    assign wr_ctrl   = wr_ok && (bus.addr == TIMER_CTRL);
    assign tick      = en_q && (pcnt_q == presc_q);

    csr_timer_ctrl_timer_counter #(.W(CSR_XLEN)) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (tick),
        .load_lo_i (wr_mt_lo),
        .load_hi_i (wr_mt_hi),
        .wdata_i   (bus.wdata),
        .cnt_o     (mtime)
    );

    always_comb begin
        pcnt_d  = pcnt_q;
        en_d    = en_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        if (wr_mt_lo)  pcnt_d = '0;
        else if (en_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
        if (wr_ctrl) begin
            en_d    = bus.wdata[CTRL_EN_BIT];
            ie_d    = bus.wdata[CTRL_IE_BIT];
            presc_d = bus.wdata[CTRL_PRESC_LSB +: PRESC_W];
        end
    end

    // Low-half compare writes lock evaluation until the high half lands, so a
    // half-updated mtimecmp can never raise a spurious interrupt.
    always_comb begin
        state_d = state_q;
        cmp_d   = cmp_q;
        if (wr_cmp_lo) begin
            cmp_d[31:0] = bus.wdata;
            state_d     = LOCKED;
        end
        if (wr_cmp_hi) begin
            cmp_d[CSR_XLEN-1:32] = bus.wdata[CSR_XLEN-33:0];
            state_d              = ARMED;
        end
        mtip_d = (state_q == ARMED) && (mtime >= cmp_q);
        irq_d  = mtip_d && ie_q;
    end

    always_comb begin
        rdata_d = '0;
        snap_d  = snap_q;
        if (rd_ok) begin
            case (bus.addr)
                TIMER_MTIME_LO: begin
                    rdata_d = mtime[31:0];
                    snap_d  = mtime[CSR_XLEN-1:32];
                end
                TIMER_MTIME_HI:    rdata_d = snap_q;
                TIMER_MTIMECMP_LO: rdata_d = cmp_q[31:0];
                TIMER_MTIMECMP_HI: rdata_d = cmp_q[CSR_XLEN-1:32];
                TIMER_CTRL: begin
                    rdata_d[CTRL_EN_BIT]                   = en_q;
                    rdata_d[CTRL_IE_BIT]                   = ie_q;
                    rdata_d[CTRL_PRESC_LSB +: PRESC_W]     = presc_q;
                end
                TIMER_STATUS: begin
                    rdata_d[STATUS_MTIP_BIT]   = mtip_q;
                    rdata_d[STATUS_LOCKED_BIT] = (state_q == LOCKED);
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            snap_q  <= '0;
            cmp_q   <= CMP_RESET;
            state_q <= ARMED;
            mtip_q  <= 1'b0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            snap_q  <= snap_d;
            cmp_q   <= cmp_d;
            state_q <= state_d;
            mtip_q  <= mtip_d;
            irq_q   <= irq_d;
            ack_q   <= bus.req;
            err_q   <= bus.req && acc_err;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign mtime_o   = mtime;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_csr_timer_ctrl.sv
// tb/tb_csr_timer_ctrl.sv - self-checking bench for csr_timer_ctrl
module tb_csr_timer_ctrl;

    logic        clk;
    logic        rst_n;
    logic [63:0] mtime;
    logic        irq;
    int          n_chk = 0;
    int          n_err = 0;

    csr_timer_ctrl_if bus_if();

    csr_timer_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .mtime_o (mtime),
        .irq_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state of the timer as seen by software.
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_snap, m_rd;
    logic [7:0]  m_presc, m_pcnt;
    logic        m_en, m_ie, m_locked, m_mtip, m_irq, m_ack, m_err;

    task automatic m_reset();
        m_time = 64'd0; m_cmp = '1; m_snap = 32'd0; m_presc = 8'd0; m_pcnt = 8'd0;
        m_en = 1'b0; m_ie = 1'b0; m_locked = 1'b0; m_mtip = 1'b0; m_irq = 1'b0;
        m_ack = 1'b0; m_err = 1'b0; m_rd = 32'd0;
    endtask

    task automatic model_step(input logic rq, input logic w, input logic [2:0] a, input logic [31:0] d);
        logic [63:0] t;
        logic [7:0]  p;
        logic        fires, bad;
        bad   = (a >= 3'd6) || (w && a == 3'd5);
        m_ack = rq;
        m_err = rq && bad;
        m_rd  = 32'd0;
        if (rq && !bad && !w) begin
            case (a)
                3'd0: begin m_rd = m_time[31:0]; end
                3'd1: m_rd = m_snap;
                3'd2: m_rd = m_cmp[31:0];
                3'd3: m_rd = m_cmp[63:32];
                3'd4: m_rd = {16'd0, m_presc, 6'd0, m_ie, m_en};
                default: m_rd = {30'd0, m_locked, m_mtip};
            endcase
            if (a == 3'd0) m_snap = m_time[63:32];
        end
        m_mtip = !m_locked && (m_time >= m_cmp);
        m_irq  = m_mtip && m_ie;
        fires  = m_en && (m_pcnt == m_presc);
        t = m_time + (fires ? 64'd1 : 64'd0);
        p = !m_en ? m_pcnt : (fires ? 8'd0 : m_pcnt + 8'd1);
        if (rq && w && !bad) begin
            case (a)
                3'd0: begin t = {m_time[63:32], d}; p = 8'd0; end
                3'd1: t = {d, m_time[31:0]};
                3'd2: begin m_cmp[31:0] = d; m_locked = 1'b1; end
                3'd3: begin m_cmp[63:32] = d; m_locked = 1'b0; end
                default: begin m_en = d[0]; m_ie = d[1]; m_presc = d[15:8]; end
            endcase
        end
        m_time = t;
        m_pcnt = p;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rq, input logic w, input logic [2:0] a, input logic [31:0] d);
        bus_if.req = rq; bus_if.we = w; bus_if.addr = a; bus_if.wdata = d;
        @(posedge clk);
        model_step(rq, w, a, d);
        #1;
        chk("model_ack",   64'(bus_if.ack),   64'(m_ack));
        chk("model_err",   64'(bus_if.err),   64'(m_err));
        chk("model_rdata", 64'(bus_if.rdata), 64'(m_rd));
        chk("model_mtime", mtime,             m_time);
        chk("model_irq",   64'(irq),          64'(m_irq));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic do_reset();
        bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = 3'd0; bus_if.wdata = 32'd0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic        rq;
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'd3, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF};
        tbl[1]  = '{1'b1, 1'b0, 3'd2, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 3'd5, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 3'd6, 32'h1234,      1'b1, 1'b1, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 3'd5, 32'h3,         1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 3'd7, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 3'd4, 32'hFFFF_FF02, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'd4, 32'h0,         1'b1, 1'b0, 32'h0000_FF02};
        tbl[9]  = '{1'b1, 1'b1, 3'd0, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
        tbl[11] = '{1'b0, 1'b0, 3'd0, 32'h0,         1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 3'd1, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 3'd1, 32'h0000_CAFE, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 3'd1, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 3'd0, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
        tbl[16] = '{1'b1, 1'b0, 3'd1, 32'h0,         1'b1, 1'b0, 32'h0000_CAFE};

        do_reset();
        chk("reset_mtime", mtime,              64'd0);
        chk("reset_irq",   64'(irq),           64'd0);
        chk("reset_ack",   64'(bus_if.ack),    64'd0);
        chk("reset_rdata", 64'(bus_if.rdata),  64'd0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rq, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_ack", i),   64'(bus_if.ack),   64'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_err", i),   64'(bus_if.err),   64'(tbl[i].e_err));
            chk($sformatf("tbl%0d_rdata", i), 64'(bus_if.rdata), 64'(tbl[i].e_rd));
        end

        // Reset asserted mid-request: state clears at once, no ack follows.
        bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.addr = 3'd2;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mtime", mtime,           64'd0);
        chk("async_rst_ack",   64'(bus_if.ack), 64'd0);
        @(posedge clk);
        #1;
        chk("async_rst_noack", 64'(bus_if.ack), 64'd0);
        bus_if.req = 1'b0;
        rst_n = 1'b1;
        m_reset();
        idle();

        // Prescaler of 3: one increment every 4 cycles.
        do_reset();
        step(1'b1, 1'b1, 3'd4, 32'h0000_0301);
        for (int k = 1; k <= 40; k++) begin
            idle();
            chk($sformatf("presc3_k%0d", k), mtime, 64'(k / 4));
        end

        // Full wrap-around.
        do_reset();
        step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 3'd4, 32'h1);
        chk("wrap_before", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        chk("wrap_after", mtime, 64'd0);

        // Tear-free read across a carry into the high half.
        do_reset();
        step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 3'd1, 32'h1);
        step(1'b1, 1'b1, 3'd4, 32'h1);
        chk("snap_start", mtime, 64'h1_FFFF_FFFE);
        step(1'b1, 1'b0, 3'd0, 32'h0);
        chk("snap_lo", 64'(bus_if.rdata), 64'hFFFF_FFFE);
        idle();
        idle();
        step(1'b1, 1'b0, 3'd1, 32'h0);
        chk("snap_hi",      64'(bus_if.rdata), 64'h1);
        chk("snap_live_hi", 64'(mtime[63:32]), 64'h2);

        // Compare lock and interrupt timing.
        do_reset();
        step(1'b1, 1'b1, 3'd0, 32'd100);
        step(1'b1, 1'b1, 3'd4, 32'h3);
        chk("irq_seq_start", mtime, 64'd100);
        step(1'b1, 1'b1, 3'd2, 32'd105);
        step(1'b1, 1'b0, 3'd5, 32'h0);
        chk("status_locked", 64'(bus_if.rdata), 64'h2);
        chk("locked_no_irq", 64'(irq), 64'd0);
        step(1'b1, 1'b1, 3'd3, 32'd0);
        begin
            int waited = 0;
            while (mtime != 64'd105 && waited < 20) begin
                chk("irq_early", 64'(irq), 64'd0);
                idle();
                waited++;
            end
            chk("reach_105", mtime, 64'd105);
        end
        chk("irq_at_match", 64'(irq), 64'd0);
        idle();
        chk("irq_rise", 64'(irq), 64'd1);
        step(1'b1, 1'b1, 3'd2, 32'd500);
        idle();
        chk("irq_drop", 64'(irq), 64'd0);

        // Writes beat a same-cycle tick; invalid accesses change nothing.
        do_reset();
        step(1'b1, 1'b1, 3'd4, 32'h1);
        idle(); idle(); idle();
        step(1'b1, 1'b1, 3'd0, 32'hAAAA_0000);
        chk("wr_lo_wins", mtime, 64'h0000_0000_AAAA_0000);
        step(1'b1, 1'b1, 3'd1, 32'h7);
        chk("wr_hi_wins", mtime, 64'h7_AAAA_0000);
        step(1'b1, 1'b1, 3'd4, 32'h0);
        step(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF);
        chk("bad6_err", 64'(bus_if.err), 64'd1);
        step(1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF);
        chk("ro_err", 64'(bus_if.err), 64'd1);
        step(1'b1, 1'b0, 3'd4, 32'h0);
        chk("ctrl_unchanged", 64'(bus_if.rdata), 64'd0);
        chk("mtime_unchanged", mtime, 64'h7_AAAA_0001);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        rq, w;
            logic [2:0]  a;
            logic [31:0] d;
            rq = ($urandom_range(0, 9) < 7);
            w  = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a <= 3'd3 && $urandom_range(0, 1) == 1)
                d = (a == 3'd1 || a == 3'd3) ? m_time[63:32] : m_time[31:0] + 32'($urandom_range(0, 40));
            if (a == 3'd4 && $urandom_range(0, 3) != 0)
                d[15:10] = 6'd0;
            step(rq, w, a, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
